test_in_monitor: RTL and testbench
==================================

TEST_IN_MONITOR -- requirements
Module: test_in_monitor

Interface
REQ-001 Parameter GATE_CYCLES, default 1000, SHALL set the measurement window length in clk cycles (range 1..2^20-1).
REQ-002 Parameter CNT_W, default 16, SHALL set the width of the edge counter and the edge_count output.
REQ-003 clk  input  1  single system clock; all logic SHALL be on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 test_in  input  1  asynchronous observed signal, e.g. a forwarded test clock output.
REQ-006 start  input  1  one-cycle request to begin a measurement.
REQ-007 busy  output  1  high from the cycle after an accepted start until done.
REQ-008 done  output  1  one-cycle pulse marking valid results.
REQ-009 edge_count  output  CNT_W  rising edges counted in the last window.
REQ-010 stuck  output  1  last window saw zero edges.
REQ-011 overflow  output  1  edge counter saturated in the last window.

Function
REQ-012 test_in SHALL pass through a 2-flop synchronizer plus one history flop; a rising edge SHALL be sync2 & ~hist.
REQ-013 The FSM SHALL have states IDLE, FLUSH, MEASURE and REPORT.
REQ-014 IDLE -> FLUSH on start; FLUSH lasts exactly 2 cycles, discarding synchronizer history, then -> MEASURE.
REQ-015 MEASURE SHALL last exactly GATE_CYCLES cycles, counted by a gate counter sized clog2(GATE_CYCLES+1), then -> REPORT.
REQ-016 REPORT SHALL last 1 cycle, assert done, then -> IDLE.
REQ-017 Latency: start sampled in cycle N -> done high in cycle N+GATE_CYCLES+3.
REQ-018 busy SHALL be high in FLUSH and MEASURE, low in IDLE and REPORT.
REQ-019 An edge detected in any MEASURE cycle, including the last, SHALL be counted; edges in FLUSH or REPORT SHALL NOT be counted.
REQ-020 The edge counter SHALL clear on entry to FLUSH and saturate at 2^CNT_W-1; an edge arriving at saturation SHALL set the internal overflow flag.
REQ-021 edge_count, stuck and overflow SHALL update only in the REPORT cycle and hold until the next REPORT.
REQ-022 stuck SHALL equal (final count == 0); overflow SHALL equal the internal flag.
REQ-023 start while busy or in REPORT SHALL be ignored, with no restart and no queuing.
REQ-024 start in the same cycle as done SHALL be ignored; a start one cycle later SHALL be accepted.

Reset
REQ-025 rst SHALL return the FSM to IDLE and clear busy, done, edge_count, stuck, overflow, the counters and the synchronizer flops to 0.
REQ-026 rst during MEASURE SHALL abort the measurement with no done pulse; a prior result SHALL be lost (outputs read 0).
REQ-027 rst SHALL take priority over start in the same cycle.

Structure
REQ-028 Package test_mon_pkg SHALL hold the FSM state enum, FLUSH_CYCLES=2 and the default GATE_CYCLES/CNT_W constants.
REQ-029 The synchronizer and edge detector SHALL be a sub-module sync_edge_det (ports clk, rst, din, rise).
REQ-030 The implementation SHALL contain no latches, no gated clocks and no asynchronous resets.

Verification
REQ-031 GATE_CYCLES=1000, test_in toggling every 4 clk cycles, start pulse -> done exactly 1003 cycles later; edge_count 125 (+/-1); stuck=0; overflow=0.
REQ-032 test_in held at 1, then at 0, one measurement each -> edge_count=0 and stuck=1 both times; busy low after each done.
REQ-033 CNT_W=4, GATE_CYCLES=100, test_in toggling every cycle -> edge_count=15 and overflow=1.
REQ-034 rst asserted 500 cycles into MEASURE -> no done pulse; all outputs 0 next cycle; a following start completes normally.
REQ-035 Second start 10 cycles after the first, and a start in the done cycle -> both ignored; exactly one done pulse; the next start after done is accepted.
REQ-036 Single test_in rising edge placed in the last MEASURE cycle -> count 1; the same edge placed in the REPORT cycle -> count 0.

Source files
------------

// File: rtl/test_mon_pkg.sv
// rtl/test_mon_pkg.sv - shared types and constants for the test input monitor
//
// Purpose: FSM state encoding, flush length and default sizing constants used
//          by test_in_monitor.
// Ports:   none (package).
package test_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FLUSH   = 2'd1,
    ST_MEASURE = 2'd2,
    ST_REPORT  = 2'd3
  } mon_state_e;

  localparam int FLUSH_CYCLES        = 2;
  localparam int FLUSH_W             = $clog2(FLUSH_CYCLES);
  localparam int DEFAULT_GATE_CYCLES = 1000;
  localparam int DEFAULT_CNT_W       = 16;

endpackage

// File: rtl/sync_edge_det.sv
// rtl/sync_edge_det.sv - two-flop synchronizer with rising-edge detector
//
// Purpose: brings an asynchronous input into the clk domain and flags a
//          one-cycle pulse for each synchronized rising edge.
// Ports:   clk  - system clock
//          rst  - synchronous active-high reset
//          din  - asynchronous input
//          rise - high for one cycle per rising edge of the synchronized din
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic sync1_q;
  logic sync2_q;
  logic hist_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  assign rise = sync2_q & ~hist_q;

endmodule

// File: rtl/test_in_monitor.sv
// rtl/test_in_monitor.sv - gated rising-edge counter for an observed test signal
//
// Purpose: on start, flushes the synchronizer, counts rising edges of test_in
//          over a fixed window of GATE_CYCLES clocks and reports the result.
// Ports:   clk        - system clock
//          rst        - synchronous active-high reset
//          test_in    - asynchronous observed signal
//          start      - one-cycle measurement request (honoured only when idle)
//          busy       - high during flush and measurement
//          done       - one-cycle pulse when results are valid
//          edge_count - edges counted in the last window (saturating)
//          stuck      - last window saw no edges
//          overflow   - edge counter saturated in the last window
module test_in_monitor
  import test_mon_pkg::*;
#(
  parameter int GATE_CYCLES = DEFAULT_GATE_CYCLES,
  parameter int CNT_W       = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             test_in,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] edge_count,
  output logic             stuck,
  output logic             overflow
);

  localparam int                GATE_W     = $clog2(GATE_CYCLES + 1);
  localparam logic [GATE_W-1:0] GATE_LAST  = GATE_W'(GATE_CYCLES - 1);
  localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX    = '1;

  logic rise;

  mon_state_e         state_q,     state_d;
  logic [FLUSH_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [GATE_W-1:0]  gate_cnt_q,  gate_cnt_d;
  logic [CNT_W-1:0]   edge_cnt_q,  edge_cnt_d;
  logic               ovf_q,       ovf_d;
  logic [CNT_W-1:0]   res_cnt_q,   res_cnt_d;
  logic               res_stuck_q, res_stuck_d;
  logic               res_ovf_q,   res_ovf_d;

  sync_edge_det u_sync_edge_det (
    .clk  (clk),
    .rst  (rst),
    .din  (test_in),
    .rise (rise)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      flush_cnt_q <= '0;
      gate_cnt_q  <= '0;
      edge_cnt_q  <= '0;
      ovf_q       <= 1'b0;
      res_cnt_q   <= '0;
      res_stuck_q <= 1'b0;
      res_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      gate_cnt_q  <= gate_cnt_d;
      edge_cnt_q  <= edge_cnt_d;
      ovf_q       <= ovf_d;
      res_cnt_q   <= res_cnt_d;
      res_stuck_q <= res_stuck_d;
      res_ovf_q   <= res_ovf_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    gate_cnt_d  = gate_cnt_q;
    edge_cnt_d  = edge_cnt_q;
    ovf_d       = ovf_q;
    res_cnt_d   = res_cnt_q;
    res_stuck_d = res_stuck_q;
    res_ovf_d   = res_ovf_q;
    busy        = 1'b0;
    done        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_FLUSH;
          flush_cnt_d = '0;
          gate_cnt_d  = '0;
          edge_cnt_d  = '0;
          ovf_d       = 1'b0;
        end
      end

      // Edges already in flight through the synchronizer when start arrives
      // surface here and are dropped.
      ST_FLUSH: begin
        busy = 1'b1;
        if (flush_cnt_q == FLUSH_LAST) begin
          state_d = ST_MEASURE;
        end else begin
          flush_cnt_d = flush_cnt_q + 1'b1;
        end
      end

      ST_MEASURE: begin
        busy = 1'b1;
        if (rise) begin
          if (edge_cnt_q == CNT_MAX) begin
            ovf_d = 1'b1;
          end else begin
            edge_cnt_d = edge_cnt_q + 1'b1;
          end
        end
        gate_cnt_d = gate_cnt_q + 1'b1;
        // Results latch from the next-state values so an edge in the final
        // window cycle is included, and become visible with done.
        if (gate_cnt_q == GATE_LAST) begin
          state_d     = ST_REPORT;
          res_cnt_d   = edge_cnt_d;
          res_stuck_d = (edge_cnt_d == '0);
          res_ovf_d   = ovf_d;
        end
      end

      ST_REPORT: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign edge_count = res_cnt_q;
  assign stuck      = res_stuck_q;
  assign overflow   = res_ovf_q;

endmodule

// File: tb/tb_test_in_monitor.sv
// tb/tb_test_in_monitor.sv - scoreboard bench for test_in_monitor
module tb_test_in_monitor;

  localparam int G1 = 1000;
  localparam int G2 = 100;

  typedef struct {
    int cyc;
    int lo;
    int hi;
    bit stuck;
    bit ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start1 = 1'b0;
  logic        start2 = 1'b0;
  logic        tin = 1'b0;
  logic        tin2 = 1'b0;
  logic        tin_lvl = 1'b0;
  bit          mode = 1'b0;
  int          tcnt = 0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  logic        busy1, done1, stuck1, ovf1;
  logic [15:0] ec1;
  logic        busy2, done2, stuck2, ovf2;
  logic [3:0]  ec2;

  exp_t q1[$];
  exp_t q2[$];

  test_in_monitor #(.GATE_CYCLES(G1), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .test_in(tin), .start(start1),
    .busy(busy1), .done(done1), .edge_count(ec1), .stuck(stuck1), .overflow(ovf1)
  );

  test_in_monitor #(.GATE_CYCLES(G2), .CNT_W(4)) dut2 (
    .clk(clk), .rst(rst), .test_in(tin2), .start(start2),
    .busy(busy2), .done(done2), .edge_count(ec2), .stuck(stuck2), .overflow(ovf2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // test_in sources change 2 time units after the edge, clear of sampling.
  always @(posedge clk) begin
    #2;
    tin2 <= ~tin2;
    if (mode) begin
      if (tcnt == 3) begin
        tcnt <= 0;
        tin  <= ~tin;
      end else begin
        tcnt <= tcnt + 1;
      end
    end else begin
      tin <= tin_lvl;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic mon_cmp(input string tag, input exp_t e, input int ec,
                         input logic st, input logic ov, input logic bz);
    chk({tag, "_done_cycle"}, 32'(cyc), 32'(e.cyc));
    chk_rng({tag, "_edge_count"}, ec, e.lo, e.hi);
    chk({tag, "_stuck"}, 32'(st), 32'(e.stuck));
    chk({tag, "_overflow"}, 32'(ov), 32'(e.ovf));
    chk({tag, "_busy_at_done"}, 32'(bz), 32'd0);
  endtask

  always @(negedge clk) begin
    if (done1 === 1'b1) begin
      if (q1.size() == 0) chk("dut1_unexpected_done", 32'd1, 32'd0);
      else mon_cmp("dut1", q1.pop_front(), int'(ec1), stuck1, ovf1, busy1);
    end
    if (done2 === 1'b1) begin
      if (q2.size() == 0) chk("dut2_unexpected_done", 32'd1, 32'd0);
      else mon_cmp("dut2", q2.pop_front(), int'(ec2), stuck2, ovf2, busy2);
    end
  end

  // All tasks below assume they are entered 1 time unit after a rising edge.
  task automatic start1_go(input bit push, input int lo, input int hi,
                           input bit st, input bit ov);
    start1 = 1'b1;
    if (push) q1.push_back('{cyc + G1 + 3, lo, hi, st, ov});
    @(posedge clk); #1;
    start1 = 1'b0;
  endtask

  task automatic wait_done(input bit which, input int limit);
    int n = 0;
    @(negedge clk);
    while (((which ? done2 : done1) !== 1'b1) && n < limit) begin
      @(negedge clk);
      n++;
    end
    if ((which ? done2 : done1) !== 1'b1) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int c0;
    step(3);
    rst = 1'b0;
    chk("rst_busy1", 32'(busy1), 32'd0);
    chk("rst_done1", 32'(done1), 32'd0);
    chk("rst_ec1", 32'(ec1), 32'd0);
    chk("rst_stuck1", 32'(stuck1), 32'd0);
    chk("rst_ovf1", 32'(ovf1), 32'd0);
    chk("rst_ec2", 32'(ec2), 32'd0);

    // Nominal: toggle every 4 cycles -> 125 edges in 1000 cycles.
    mode = 1'b1;
    start1_go(1'b1, 124, 126, 1'b0, 1'b0);
    chk("busy_after_start", 32'(busy1), 32'd1);
    wait_done(1'b0, G1 + 50);
    step(1);

    // Saturation on the narrow instance.
    start2 = 1'b1;
    q2.push_back('{cyc + G2 + 3, 15, 15, 1'b0, 1'b1});
    step(1);
    start2 = 1'b0;
    wait_done(1'b1, G2 + 50);
    step(1);

    // Held high, then held low.
    mode = 1'b0; tin_lvl = 1'b1;
    step(6);
    start1_go(1'b1, 0, 0, 1'b1, 1'b0);
    wait_done(1'b0, G1 + 50);
    step(1);
    chk("busy_after_done_hi", 32'(busy1), 32'd0);
    tin_lvl = 1'b0;
    step(6);
    start1_go(1'b1, 0, 0, 1'b1, 1'b0);
    wait_done(1'b0, G1 + 50);
    step(1);
    chk("busy_after_done_lo", 32'(busy1), 32'd0);

    // Reset 500 cycles into MEASURE aborts and clears the prior stuck result.
    c0 = cyc;
    start1_go(1'b0, 0, 0, 1'b0, 1'b0);
    wait_cyc(c0 + 503);
    rst = 1'b1;
    step(1);
    chk("abort_busy", 32'(busy1), 32'd0);
    chk("abort_done", 32'(done1), 32'd0);
    chk("abort_ec", 32'(ec1), 32'd0);
    chk("abort_stuck", 32'(stuck1), 32'd0);
    chk("abort_ovf", 32'(ovf1), 32'd0);
    rst = 1'b0;
    step(1);
    mode = 1'b1;
    start1_go(1'b1, 124, 126, 1'b0, 1'b0);
    wait_done(1'b0, G1 + 50);
    step(1);

    // Start while busy and start in the done cycle are ignored;
    // a start one cycle after done is accepted.
    c0 = cyc;
    start1_go(1'b1, 124, 126, 1'b0, 1'b0);
    wait_cyc(c0 + 10);
    start1 = 1'b1;
    step(1);
    start1 = 1'b0;
    wait_done(1'b0, G1 + 50);
    start1 = 1'b1;
    step(1);
    q1.push_back('{cyc + G1 + 3, 124, 126, 1'b0, 1'b0});
    step(1);
    start1 = 1'b0;
    wait_done(1'b0, G1 + 50);
    step(1);

    // Single edge in the last MEASURE cycle counts; in REPORT it does not.
    mode = 1'b0; tin_lvl = 1'b0;
    step(6);
    c0 = cyc;
    start1_go(1'b1, 1, 1, 1'b0, 1'b0);
    wait_cyc(c0 + G1);
    tin_lvl = 1'b1;
    wait_done(1'b0, G1 + 50);
    step(1);
    tin_lvl = 1'b0;
    step(6);
    c0 = cyc;
    start1_go(1'b1, 0, 0, 1'b1, 1'b0);
    wait_cyc(c0 + G1 + 1);
    tin_lvl = 1'b1;
    wait_done(1'b0, G1 + 50);
    step(6);

    chk("pending_dut1", 32'(q1.size()), 32'd0);
    chk("pending_dut2", 32'(q2.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
